// File: rtl/drac_pkg.sv
// Shared types for the graduation list and commit stage, plus the store/AMO
// classifier that both blocks use so they never disagree on what a store is.
package drac_pkg;

  localparam int GL_ENTRIES = 32;
  localparam int PHREG_W    = 6;
  localparam int PHVREG_W   = 6;

  typedef logic [$clog2(GL_ENTRIES)-1:0] gl_index_t;
  typedef logic [PHREG_W-1:0]            phreg_t;
  typedef logic [PHVREG_W-1:0]           phvreg_t;

  typedef enum logic [2:0] {
    INSTR_ALU,
    INSTR_LOAD,
    INSTR_STORE,
    INSTR_AMO,
    INSTR_CSR,
    INSTR_FENCE,
    INSTR_BRANCH
  } instr_type_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  cause;
    logic [31:0] origin;
  } exception_t;

  typedef struct packed {
    logic        valid;
    instr_type_t instr_type;
    logic        stall_csr_fence;
    exception_t  exception;
    phreg_t      old_prd;
    phvreg_t     old_pvd;
  } gl_instruction_t;

  function automatic logic is_store_or_amo(instr_type_t t);
    return (t == INSTR_STORE) || (t == INSTR_AMO);
  endfunction

endpackage

// File: rtl/commit_unit.sv
// In-order commit stage: pops the graduation-list head, retires it, releases
// old physical registers and sequences stores, CSRs/fences and traps.
module commit_unit
  import drac_pkg::*;
#(
  parameter int COUNTER_W = 64
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  gl_instruction_t      instruction_i,
  input  gl_index_t            commit_gl_entry_i,
  input  logic                 gl_empty_i,
  input  logic                 stall_i,
  output logic                 read_head_o,
  output logic                 free_reg_valid_o,
  output phreg_t               free_reg_o,
  output logic                 free_vreg_valid_o,
  output phvreg_t              free_vreg_o,
  output logic                 store_commit_o,
  input  logic                 store_ack_i,
  output logic                 csr_req_o,
  input  logic                 csr_ack_i,
  output logic                 flush_commit_o,
  output logic                 xcpt_valid_o,
  output exception_t           xcpt_o,
  output gl_index_t            xcpt_gl_entry_o,
  output logic [COUNTER_W-1:0] retired_count_o
);

  typedef enum logic [1:0] {RUN, WAIT_STORE, WAIT_CSR, FLUSH} state_t;

  state_t               state_q, state_d;
  logic [COUNTER_W-1:0] count_q, count_d;
  phreg_t               pend_prd_q, pend_prd_d;
  phvreg_t              pend_pvd_q, pend_pvd_d;
  logic                 xcpt_valid_q, xcpt_valid_d;
  exception_t           xcpt_q, xcpt_d;
  gl_index_t            xcpt_entry_q, xcpt_entry_d;

  logic    is_mem, blocking, retire;
  phreg_t  ret_prd;
  phvreg_t ret_pvd;

  assign is_mem   = is_store_or_amo(instruction_i.instr_type);
  assign blocking = instruction_i.exception.valid | is_mem | instruction_i.stall_csr_fence;

  // The head is only valid for one cycle, so blocking instructions park their
  // register releases in pend_* until the ack arrives.
  always_comb begin
    state_d        = state_q;
    pend_prd_d     = pend_prd_q;
    pend_pvd_d     = pend_pvd_q;
    xcpt_valid_d   = 1'b0;
    xcpt_d         = xcpt_q;
    xcpt_entry_d   = xcpt_entry_q;
    retire         = 1'b0;
    ret_prd        = instruction_i.old_prd;
    ret_pvd        = instruction_i.old_pvd;
    read_head_o    = 1'b0;
    store_commit_o = 1'b0;
    csr_req_o      = 1'b0;
    flush_commit_o = 1'b0;
    if (rstn_i) begin
      case (state_q)
        RUN: begin
          read_head_o = ~gl_empty_i & ~stall_i & ~(instruction_i.valid & blocking);
          if (instruction_i.valid) begin
            if (instruction_i.exception.valid) begin
              xcpt_valid_d = 1'b1;
              xcpt_d       = instruction_i.exception;
              xcpt_entry_d = commit_gl_entry_i;
              state_d      = FLUSH;
            end else if (is_mem) begin
              pend_prd_d = instruction_i.old_prd;
              pend_pvd_d = instruction_i.old_pvd;
              state_d    = WAIT_STORE;
            end else if (instruction_i.stall_csr_fence) begin
              pend_prd_d = instruction_i.old_prd;
              pend_pvd_d = instruction_i.old_pvd;
              state_d    = WAIT_CSR;
            end else begin
              retire = 1'b1;
            end
          end
        end
        WAIT_STORE: begin
          store_commit_o = 1'b1;
          ret_prd        = pend_prd_q;
          ret_pvd        = pend_pvd_q;
          if (store_ack_i) begin
            retire  = 1'b1;
            state_d = RUN;
          end
        end
        WAIT_CSR: begin
          csr_req_o = 1'b1;
          ret_prd   = pend_prd_q;
          ret_pvd   = pend_pvd_q;
          if (csr_ack_i) begin
            retire  = 1'b1;
            state_d = FLUSH;
          end
        end
        FLUSH: begin
          flush_commit_o = 1'b1;
          state_d        = RUN;
        end
        default: state_d = RUN;
      endcase
    end
    count_d = count_q + {{(COUNTER_W-1){1'b0}}, retire};
  end

  always_comb begin
    free_reg_valid_o  = retire & (ret_prd != '0);
    free_vreg_valid_o = retire & (ret_pvd != '0);
    free_reg_o        = free_reg_valid_o  ? ret_prd : '0;
    free_vreg_o       = free_vreg_valid_o ? ret_pvd : '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= RUN;
      count_q      <= '0;
      pend_prd_q   <= '0;
      pend_pvd_q   <= '0;
      xcpt_valid_q <= 1'b0;
      xcpt_q       <= '0;
      xcpt_entry_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      pend_prd_q   <= pend_prd_d;
      pend_pvd_q   <= pend_pvd_d;
      xcpt_valid_q <= xcpt_valid_d;
      xcpt_q       <= xcpt_d;
      xcpt_entry_q <= xcpt_entry_d;
    end
  end

  assign xcpt_valid_o    = xcpt_valid_q;
  assign xcpt_o          = xcpt_q;
  assign xcpt_gl_entry_o = xcpt_entry_q;
  assign retired_count_o = count_q;

  // The GL only presents a head after a granted pop, which is only possible in RUN.
  assert property (@(posedge clk_i) disable iff (!rstn_i) instruction_i.valid |-> state_q == RUN);

endmodule
